// File: rtl/rv_regfile_mp.sv
`default_nettype none
//============================================================================
// Module   : rv_regfile_mp
// Purpose  : Parametrised multi-port integer register file for the RV32
//            pipeline. Synchronous 1-cycle reads with optional same-edge
//            write forwarding, a per-register busy scoreboard for hazard
//            detection, and a combinational debug read/write port.
// Ports    :
//    clk          rising-edge clock
//    rst          asynchronous active-high reset
//    wr_en        [NWR]         per-port write enable
//    wr_addr      [NWR*AW]      packed write addresses (port i at i*AW)
//    wr_data      [NWR*XLEN]    packed write data
//    rd_en        [NRD]         per-port read enable
//    rd_addr      [NRD*AW]      packed read addresses
//    rd_data      [NRD*XLEN]    packed registered read data
//    sb_set_en    mark sb_set_addr busy
//    sb_set_addr  [AW]          destination register being issued
//    sb_busy      [NREGS]       registered busy bit per register
//    dbg_wr_en    debug write enable
//    dbg_wr_addr  [AW]          debug write address
//    dbg_wr_data  [XLEN]        debug write data
//    dbg_rd_addr  [AW]          debug read address
//    dbg_rd_data  [XLEN]        combinational debug read data
// Revision : 1.0 - initial release
//============================================================================
module rv_regfile_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NRD-1:0]      rd_en,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   input  logic                sb_set_en,
   input  logic [AW-1:0]       sb_set_addr,
   output logic [NREGS-1:0]    sb_busy,
   input  logic                dbg_wr_en,
   input  logic [AW-1:0]       dbg_wr_addr,
   input  logic [XLEN-1:0]     dbg_wr_data,
   input  logic [AW-1:0]       dbg_rd_addr,
   output logic [XLEN-1:0]     dbg_rd_data
);

   logic [XLEN-1:0]     mem_q [NREGS];
   logic [XLEN-1:0]     mem_d [NREGS];
   logic [NRD*XLEN-1:0] rd_data_q;
   logic [NRD*XLEN-1:0] rd_data_d;
   logic [NREGS-1:0]    sb_q;
   logic [NREGS-1:0]    sb_d;

   // Next register contents. Ports are scanned in ascending order so the
   // highest-index enabled port overrides lower ones; the debug write is
   // applied last so it wins over every port. Addresses >= NREGS match no
   // entry and therefore fall away without extra range checks.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         mem_d[r] = mem_q[r];
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
               mem_d[r] = wr_data[w*XLEN +: XLEN];
            end
         end
         if (dbg_wr_en && (dbg_wr_addr == AW'(r))) begin
            mem_d[r] = dbg_wr_data;
         end
         if ((ZERO_REG != 0) && (r == 0)) begin
            mem_d[r] = '0;
         end
      end
   end

   // Read ports. With forwarding enabled the post-write view (mem_d) is
   // sampled, which carries the exact commit priority for free.
   always_comb begin
      rd_data_d = rd_data_q;
      for (int p = 0; p < NRD; p++) begin
         if (rd_en[p]) begin
            rd_data_d[p*XLEN +: XLEN] = '0;
            for (int r = 0; r < NREGS; r++) begin
               if (rd_addr[p*AW +: AW] == AW'(r)) begin
                  rd_data_d[p*XLEN +: XLEN] = (BYPASS != 0) ? mem_d[r] : mem_q[r];
               end
            end
         end
      end
   end

   // Scoreboard: a new producer (set) supersedes a retiring one (clear).
   // Debug writes deliberately leave the scoreboard untouched.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         sb_d[r] = sb_q[r];
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
               sb_d[r] = 1'b0;
            end
         end
         if (sb_set_en && (sb_set_addr == AW'(r))) begin
            sb_d[r] = 1'b1;
         end
         if ((ZERO_REG != 0) && (r == 0)) begin
            sb_d[r] = 1'b0;
         end
      end
   end

   // Debug read taps the committed array only, never in-flight writes.
   always_comb begin
      dbg_rd_data = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (dbg_rd_addr == AW'(r)) begin
            dbg_rd_data = mem_q[r];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            mem_q[r] <= '0;
         end
         rd_data_q <= '0;
         sb_q      <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            mem_q[r] <= mem_d[r];
         end
         rd_data_q <= rd_data_d;
         sb_q      <= sb_d;
      end
   end

   assign rd_data = rd_data_q;
   assign sb_busy = sb_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_regfile_mp.sv
`default_nettype none
//============================================================================
// Module   : tb_rv_regfile_mp
// Purpose  : Directed self-checking bench for rv_regfile_mp. Two instances
//            share one stimulus stream:
//              A: NREGS=32, NWR=2, BYPASS=1, ZERO_REG=1
//              B: NREGS=24, NWR=2, BYPASS=0, ZERO_REG=0
//            Both use a 5-bit address, so the same buses drive both.
// Revision : 1.0 - initial release
//============================================================================
module tb_rv_regfile_mp;

   logic        clk;
   logic        rst;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic        sb_set_en;
   logic [4:0]  sb_set_addr;
   logic        dbg_wr_en;
   logic [4:0]  dbg_wr_addr;
   logic [31:0] dbg_wr_data;
   logic [4:0]  dbg_rd_addr;

   logic [63:0] a_rd_data;
   logic [31:0] a_sb;
   logic [31:0] a_dbg;
   logic [63:0] b_rd_data;
   logic [23:0] b_sb;
   logic [31:0] b_dbg;

   int n_chk;
   int n_pass;

   rv_regfile_mp #(
      .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
   ) u_dut_a (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_busy(a_sb),
      .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
      .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(a_dbg)
   );

   rv_regfile_mp #(
      .XLEN(32), .NREGS(24), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(0)
   ) u_dut_b (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_busy(b_sb),
      .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
      .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(b_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic idle();
      wr_en       = '0;
      wr_addr     = '0;
      wr_data     = '0;
      rd_en       = '0;
      rd_addr     = '0;
      sb_set_en   = 1'b0;
      sb_set_addr = '0;
      dbg_wr_en   = 1'b0;
      dbg_wr_addr = '0;
      dbg_wr_data = '0;
      dbg_rd_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // ---- reset state
      chk("rst_a_rd", a_rd_data, 64'h0);
      chk("rst_a_sb", 64'(a_sb), 64'h0);
      chk("rst_b_sb", 64'(b_sb), 64'h0);
      rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
      step();
      chk("rst_a_x5_x31", a_rd_data, 64'h0);
      chk("rst_b_x5_x31", b_rd_data, 64'h0);

      // ---- basic write then read on port 1
      idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hDEADBEEF};
      step();
      idle(); rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
      step();
      chk("wr_a_x7", 64'(a_rd_data[63:32]), 64'hDEADBEEF);
      chk("wr_b_x7", 64'(b_rd_data[63:32]), 64'hDEADBEEF);
      idle(); rd_addr = {5'd5, 5'd5};
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_a", 64'(a_rd_data[63:32]), 64'hDEADBEEF);
      end
      chk("hold_b", 64'(b_rd_data[63:32]), 64'hDEADBEEF);

      // ---- reset asserted mid-write to x3, checked before any edge
      wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h1234};
      #2; rst = 1'b1;
      #1;
      chk("arst_a_rd", a_rd_data, 64'h0);
      chk("arst_b_rd", b_rd_data, 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(); rd_en = 2'b11; rd_addr = {5'd7, 5'd3};
      step();
      chk("arst_a_x3_x7", a_rd_data, 64'h0);
      chk("arst_b_x3_x7", b_rd_data, 64'h0);

      // ---- collision and bypass
      idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h55};
      step();
      idle(); wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'h22, 32'h11};
      rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
      step();
      chk("byp_a_x4", 64'(a_rd_data[31:0]), 64'h22);
      chk("nobyp_b_x4", 64'(b_rd_data[31:0]), 64'h55);
      idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
      step();
      chk("reread_a_x4", 64'(a_rd_data[31:0]), 64'h22);
      chk("reread_b_x4", 64'(b_rd_data[31:0]), 64'h22);
      idle(); wr_en = 2'b11; wr_addr = {5'd4, 5'd4}; wr_data = {32'h22, 32'h11};
      dbg_wr_en = 1'b1; dbg_wr_addr = 5'd4; dbg_wr_data = 32'h33;
      rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
      step();
      chk("dbgwin_a_x4", 64'(a_rd_data[31:0]), 64'h33);
      chk("dbgwin_b_x4", 64'(b_rd_data[31:0]), 64'h22);
      idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
      step();
      chk("dbgwin_b_reread", 64'(b_rd_data[31:0]), 64'h33);

      // ---- non-colliding writes from both ports in one cycle
      idle(); wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'hB, 32'hA};
      step();
      idle(); rd_en = 2'b11; rd_addr = {5'd2, 5'd1};
      step();
      chk("dual_a", a_rd_data, {32'hB, 32'hA});
      chk("dual_b", b_rd_data, {32'hB, 32'hA});

      // ---- register 0
      idle(); wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
      dbg_wr_en = 1'b1; dbg_wr_addr = 5'd0; dbg_wr_data = 32'hFFFFFFFF;
      sb_set_en = 1'b1; sb_set_addr = 5'd0;
      rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
      step();
      chk("x0_a_rd", a_rd_data, 64'h0);
      chk("x0_b_rd_old", b_rd_data, 64'h0);
      chk("x0_a_sb", 64'(a_sb[0]), 64'h0);
      chk("x0_b_sb", 64'(b_sb[0]), 64'h1);
      idle(); rd_en = 2'b11; rd_addr = {5'd0, 5'd0}; dbg_rd_addr = 5'd0;
      step();
      chk("x0_a_rd2", a_rd_data, 64'h0);
      chk("x0_b_rd2", b_rd_data, {32'hFFFFFFFF, 32'hFFFFFFFF});
      chk("x0_a_dbg", 64'(a_dbg), 64'h0);
      chk("x0_b_dbg", 64'(b_dbg), 64'hFFFFFFFF);

      // ---- scoreboard
      idle(); sb_set_en = 1'b1; sb_set_addr = 5'd9;
      step();
      chk("sb_set_a", 64'(a_sb[9]), 64'h1);
      chk("sb_set_b", 64'(b_sb[9]), 64'h1);
      idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
      step();
      chk("sb_clr_a", 64'(a_sb[9]), 64'h0);
      chk("sb_clr_b", 64'(b_sb[9]), 64'h0);
      idle(); sb_set_en = 1'b1; sb_set_addr = 5'd9;
      wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h98, 32'h0};
      step();
      chk("sb_setwin_a", 64'(a_sb[9]), 64'h1);
      chk("sb_setwin_b", 64'(b_sb[9]), 64'h1);
      idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h97};
      step();
      chk("sb_clr2_a", 64'(a_sb[9]), 64'h0);

      // ---- debug port timing
      idle(); dbg_wr_en = 1'b1; dbg_wr_addr = 5'd12; dbg_wr_data = 32'hA5A5A5A5;
      dbg_rd_addr = 5'd12;
      #1;
      chk("dbg_pre_a", 64'(a_dbg), 64'h0);
      chk("dbg_pre_b", 64'(b_dbg), 64'h0);
      step();
      chk("dbg_post_a", 64'(a_dbg), 64'hA5A5A5A5);
      chk("dbg_post_b", 64'(b_dbg), 64'hA5A5A5A5);

      // ---- address 30: valid for A, out of range for B
      idle(); wr_en = 2'b01; wr_addr = {5'd0, 5'd30}; wr_data = {32'h0, 32'h777};
      sb_set_en = 1'b1; sb_set_addr = 5'd30;
      step();
      idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd30}; dbg_rd_addr = 5'd30;
      step();
      chk("oor_a_rd", 64'(a_rd_data[31:0]), 64'h777);
      chk("oor_b_rd", 64'(b_rd_data[31:0]), 64'h0);
      chk("oor_b_dbg", 64'(b_dbg), 64'h0);
      chk("oor_a_sb", 64'(a_sb), 64'h40000000);
      chk("oor_b_sb", 64'(b_sb), 64'h000001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rv_regfile_mp.md
Name: rv_regfile_mp

Overview:
Parametrised multi-port integer register file for the next-generation RV32 pipelined core. It supports configurable width, depth, read-port count and write-port count, with synchronous reads and optional same-cycle write-to-read bypass. It also holds a per-register busy scoreboard for hazard detection and a combinational debug port for APB access while halted. It sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of architectural registers (2..64); AW = $clog2(NREGS)
NRD, 2, number of synchronous read ports (1..4)
NWR, 1, number of write ports (1..2); higher index has priority
BYPASS, 1, 1 = a same-cycle write is forwarded to the read output; 0 = old value is returned
ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  packed write addresses (port i at bits [i*AW +: AW])
wr_data  in  NWR*XLEN  packed write data
rd_en  in  NRD  per-port read enable
rd_addr  in  NRD*AW  packed read addresses
rd_data  out  NRD*XLEN  packed registered read data
sb_set_en  in  1  mark sb_set_addr busy (instruction issued with a destination)
sb_set_addr  in  AW  destination register being issued
sb_busy  out  NREGS  registered busy bit per register
dbg_wr_en  in  1  debug write enable (asserted only when the core is halted)
dbg_wr_addr  in  AW  debug write address
dbg_wr_data  in  XLEN  debug write data
dbg_rd_addr  in  AW  debug read address
dbg_rd_data  out  XLEN  combinational debug read data

Behaviour:
- Reset (rst high, asynchronous): all registers are cleared to 0, rd_data is cleared to 0 and sb_busy is cleared to 0, immediately and independent of clk. Reset asserted mid-operation discards any in-flight write. The first write after reset takes effect at the first rising edge following rst deassertion.
- Writes are committed on the rising edge.
  - Address collision: dbg_wr_en wins over every write port; otherwise the highest-index enabled port wins.
  - Non-colliding writes from different ports commit in the same cycle.
- Register 0 (ZERO_REG=1): writes are ignored, reads return 0, and the register is never busy.
- Addresses >= NREGS: writes are ignored, reads return 0, scoreboard set is ignored.
- Read latency is 1 cycle. When rd_en[i] is high at edge N, rd_data[i] holds the value for rd_addr[i] from edge N onward. When rd_en[i] is low, rd_data[i] holds its previous value.
- Bypass (BYPASS=1): if any write (debug or port) commits to rd_addr[i] at the same edge, rd_data[i] receives that write's data, using the same priority as the commit. With BYPASS=0, rd_data[i] receives the pre-write value.
- Debug read is combinational from the register array with no bypass. It reflects writes only after they commit.
- Scoreboard, per register r, evaluated at each edge:
  - set = sb_set_en && sb_set_addr==r
  - clr = any wr_en[i] && wr_addr[i]==r
  - set has priority over clr, because a new producer supersedes the retiring one
  - sb_busy[r] updates from these; a debug write does not change sb_busy
- All port widths are derived from the parameters. No arithmetic is performed on data.

Test Plan:
1. Reset, then read: assert rst for 2 cycles, release, read x5 and x31 -> both rd_data ports = 0 and sb_busy = 0; assert rst mid-write to x3 -> x3 reads 0 after release.
2. Basic write/read: write x7=0xDEADBEEF on port 0, read x7 on port 1 the next cycle -> rd_data1 = 0xDEADBEEF one cycle after rd_en; with rd_en low for 3 cycles -> the value is held.
3. Bypass and collision (NWR=2): port 0 writes x4=0x11, port 1 writes x4=0x22, and rd_addr0=x4 in the same cycle -> BYPASS=1 gives rd_data0=0x22; BYPASS=0 gives the old value, followed by 0x22 on the next read. Adding dbg_wr x4=0x33 in that cycle -> 0x33.
4. Zero register: write x0=0xFFFFFFFF on all ports and debug, plus sb_set x0 -> reads return 0 and sb_busy[0]=0. With ZERO_REG=0, x0 reads 0xFFFFFFFF.
5. Scoreboard: sb_set x9 -> busy[9]=1 the next cycle; write x9 -> busy[9]=0. Setting x9 and writing x9 in the same cycle -> busy[9] remains 1.
6. Debug and out of range (NREGS=24): dbg_wr x12=0xA5A5A5A5 -> dbg_rd_data = 0xA5A5A5A5 after the edge and not before. Writing address 30 -> read returns 0.
